// File: rtl/mole_pkg.sv
// Purpose: shared types and constants for the whack-a-mole game controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPAWN  = 2'd1,
        ACTIVE = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam int         NUM_HOLES = 8;
    localparam int         HOLE_W    = $clog2(NUM_HOLES);
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Mole hole for a new round: avoid repeating the previous round's hole.
    function automatic logic [HOLE_W-1:0] pick_hole(
        input logic [HOLE_W-1:0] raw,
        input logic              prev_vld,
        input logic [HOLE_W-1:0] prev
    );
        logic [HOLE_W-1:0] h;
        h = raw;
        if (prev_vld && (h == prev)) begin
            h = h + HOLE_W'(1);
        end
        return h;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Purpose: free-running 8-bit Galois LFSR used to pick mole holes.
// Latency: advances once per clock in every state; seeded on reset.
// Backpressure: none, never stalls.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_BTN,
    output logic [7:0] lfsr_o
);

    // Shift right and fold the taps in when the bit falling out is 1; a
    // nonzero seed keeps the sequence from ever reaching zero.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            lfsr_o <= LFSR_SEED;
        end else begin
            lfsr_o <= (lfsr_o >> 1) ^ (lfsr_o[0] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Purpose: whack-a-mole round timer, mole picker, hit detection and scoring.
// Latency: button press seen at a clock edge updates grid/score at that edge (one register).
// Backpressure: none; optional MOLE_MISS_PENALTY_EN makes wrong presses cost one point.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int ROUND_CYCLES = 50_000_000,
    parameter int NUM_ROUNDS   = 30,
    parameter int SCORE_W      = 8
) (
    input  logic               CLK,
    input  logic               RST_BTN,
    input  logic               start,
    input  logic [7:0]         btn,
    output logic [7:0]         random_num,
    output logic [7:0]         mole_hit,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         round_cnt,
    output logic               game_over
);

    localparam int                 TIMER_W     = $clog2(ROUND_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(ROUND_CYCLES - 1);
    localparam logic [7:0]         ROUNDS_LAST = 8'(NUM_ROUNDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

    state_t              state, state_nxt;
    logic [7:0]          btn_q;
    logic                start_q;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [HOLE_W-1:0]   hole_q, hole_nxt;
    logic                hole_vld, hole_vld_nxt;
    logic [7:0]          random_num_nxt, mole_hit_nxt, round_cnt_nxt;
    logic [SCORE_W-1:0]  score_nxt;

    logic [7:0]          lfsr;
    logic                lfsr_unused;
    logic [7:0]          press;
    logic                start_p;
    logic                hit;
    logic                expire;
    logic [7:0]          round_inc;
    logic [HOLE_W-1:0]   spawn_hole;

    mole_lfsr u_lfsr (
        .CLK     (CLK),
        .RST_BTN (RST_BTN),
        .lfsr_o  (lfsr)
    );

    // Only the low bits choose the hole; the rest of the LFSR just provides sequence length.
    assign lfsr_unused = ^lfsr[7:HOLE_W];

    assign press      = btn & ~btn_q;
    assign start_p    = start & ~start_q;
    assign hit        = (state == ACTIVE) && (|(press & random_num));
    assign expire     = (state == ACTIVE) && (timer == TIMER_LAST);
    assign round_inc  = round_cnt + 8'd1;
    assign spawn_hole = pick_hole(lfsr[HOLE_W-1:0], hole_vld, hole_q);

    // State register and input edge-detect history.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            state   <= IDLE;
            btn_q   <= 8'h00;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            btn_q   <= btn;
            start_q <= start;
        end
    end

    // Next-state decode: start edges only matter when no round is running.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_p) state_nxt = SPAWN;
            SPAWN:   state_nxt = ACTIVE;
            ACTIVE:  if (expire) state_nxt = (round_inc == ROUNDS_LAST) ? OVER : SPAWN;
            OVER:    if (start_p) state_nxt = SPAWN;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for grid, timer, score and round counter.
    always_comb begin
        random_num_nxt = random_num;
        mole_hit_nxt   = mole_hit;
        score_nxt      = score;
        round_cnt_nxt  = round_cnt;
        timer_nxt      = timer;
        hole_nxt       = hole_q;
        hole_vld_nxt   = hole_vld;
        case (state)
            IDLE, OVER: begin
                random_num_nxt = 8'h00;
                mole_hit_nxt   = 8'h00;
                if (start_p) begin
                    score_nxt     = '0;
                    round_cnt_nxt = 8'h00;
                    hole_vld_nxt  = 1'b0;
                end
            end
            SPAWN: begin
                random_num_nxt = 8'd1 << spawn_hole;
                mole_hit_nxt   = 8'h00;
                timer_nxt      = '0;
                hole_nxt       = spawn_hole;
                hole_vld_nxt   = 1'b1;
            end
            ACTIVE: begin
                timer_nxt = timer + TIMER_W'(1);
                if (hit) begin
                    random_num_nxt = 8'h00;
                    mole_hit_nxt   = random_num;
                    if (score != SCORE_MAX) score_nxt = score + SCORE_ONE;
                end
`ifdef MOLE_MISS_PENALTY_EN
                else if ((|press) && (score != '0)) begin
                    score_nxt = score - SCORE_ONE;
                end
`endif
                // Round end wins over the hit marker, but the point above still counts.
                if (expire) begin
                    random_num_nxt = 8'h00;
                    mole_hit_nxt   = 8'h00;
                    round_cnt_nxt  = round_inc;
                end
            end
            default: begin
                random_num_nxt = 8'h00;
                mole_hit_nxt   = 8'h00;
            end
        endcase
    end

    // Datapath registers; reset aborts any game in progress.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            random_num <= 8'h00;
            mole_hit   <= 8'h00;
            score      <= '0;
            round_cnt  <= 8'h00;
            timer      <= '0;
            hole_q     <= '0;
            hole_vld   <= 1'b0;
        end else begin
            random_num <= random_num_nxt;
            mole_hit   <= mole_hit_nxt;
            score      <= score_nxt;
            round_cnt  <= round_cnt_nxt;
            timer      <= timer_nxt;
            hole_q     <= hole_nxt;
            hole_vld   <= hole_vld_nxt;
        end
    end

    // Game-over flag follows the OVER state directly.
    always_comb begin
        game_over = (state == OVER);
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
module tb_mole_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] btn;
    logic [7:0] random_num;
    logic [7:0] mole_hit;
    logic [7:0] score;
    logic [7:0] round_cnt;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_lfsr;
    logic [2:0] prev_h;
    logic [2:0] cur_h;

`ifdef MOLE_MISS_PENALTY_EN
    localparam logic [7:0] EXP_AFTER_WRONG = 8'd1;
    localparam logic [7:0] EXP_AFTER_BOTH  = 8'd2;
`else
    localparam logic [7:0] EXP_AFTER_WRONG = 8'd2;
    localparam logic [7:0] EXP_AFTER_BOTH  = 8'd3;
`endif

    mole_game_ctrl #(
        .ROUND_CYCLES (16),
        .NUM_ROUNDS   (4),
        .SCORE_W      (8)
    ) dut (
        .CLK        (clk),
        .RST_BTN    (rst_n),
        .start      (start),
        .btn        (btn),
        .random_num (random_num),
        .mole_hit   (mole_hit),
        .score      (score),
        .round_cnt  (round_cnt),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Galois LFSR, stepped on the same edges as the design.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 8'h01;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("no_overlap", {24'h0, random_num & mole_hit}, 32'h0);
        end
    endtask

    function automatic logic [2:0] pick(input logic [7:0] l, input logic pv, input logic [2:0] p);
        logic [2:0] h;
        h = l[2:0];
        if (pv && h == p) h = h + 3'd1;
        return h;
    endfunction

    // Start edge from IDLE/OVER: one SPAWN cycle, then first mole is up.
    task automatic start_game();
        logic [7:0] l;
        start = 1'b1;
        tick(1);
        chk("spawn_go_low", {31'h0, game_over}, 32'h0);
        l = m_lfsr;
        start = 1'b0;
        cur_h = pick(l, 1'b0, 3'd0);
        tick(1);
        chk("first_mole", {24'h0, random_num}, {24'h0, 8'd1 << cur_h});
        chk("first_hit_clr", {24'h0, mole_hit}, 32'h0);
        chk("start_score", {24'h0, score}, 32'h0);
        chk("start_round", {24'h0, round_cnt}, 32'h0);
        prev_h = cur_h;
    endtask

    // Called in the SPAWN cycle that follows an expiry.
    task automatic next_round();
        logic [7:0] l;
        l = m_lfsr;
        cur_h = pick(l, 1'b1, prev_h);
        tick(1);
        chk("next_mole", {24'h0, random_num}, {24'h0, 8'd1 << cur_h});
        chk("no_repeat", {24'h0, random_num & (8'd1 << prev_h)}, 32'h0);
        prev_h = cur_h;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        btn   = 8'h00;
        prev_h = 3'd0;
        cur_h  = 3'd0;

        // Reset and idle
        tick(3);
        chk("rst_rn", {24'h0, random_num}, 32'h0);
        chk("rst_mh", {24'h0, mole_hit}, 32'h0);
        chk("rst_score", {24'h0, score}, 32'h0);
        chk("rst_round", {24'h0, round_cnt}, 32'h0);
        chk("rst_go", {31'h0, game_over}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle_outs", {7'h0, random_num, mole_hit, score, round_cnt, game_over}, 32'h0);
        end

        // Game 1, round 1: single hit at timer 5, then hold the button
        start_game();
        tick(5);
        btn = 8'd1 << cur_h;
        tick(1);
        chk("hit_rn", {24'h0, random_num}, 32'h0);
        chk("hit_mh", {24'h0, mole_hit}, {24'h0, 8'd1 << cur_h});
        chk("hit_score", {24'h0, score}, 32'd1);
        tick(8);
        chk("hold_score", {24'h0, score}, 32'd1);
        chk("hold_mh", {24'h0, mole_hit}, {24'h0, 8'd1 << cur_h});
        btn = 8'h00;
        tick(2);
        chk("r1_end_rn", {24'h0, random_num}, 32'h0);
        chk("r1_end_mh", {24'h0, mole_hit}, 32'h0);
        chk("r1_end_round", {24'h0, round_cnt}, 32'd1);
        chk("r1_end_score", {24'h0, score}, 32'd1);

        // Round 2: correct press exactly in the expiry cycle
        next_round();
        tick(15);
        btn = 8'd1 << cur_h;
        tick(1);
        chk("coll_score", {24'h0, score}, 32'd2);
        chk("coll_round", {24'h0, round_cnt}, 32'd2);
        chk("coll_rn", {24'h0, random_num}, 32'h0);
        chk("coll_mh", {24'h0, mole_hit}, 32'h0);
        btn = 8'h00;

        // Round 3: wrong press, then wrong+correct together
        next_round();
        tick(3);
        btn = ~(8'd1 << cur_h);
        tick(1);
        chk("wrong_score", {24'h0, score}, {24'h0, EXP_AFTER_WRONG});
        chk("wrong_rn", {24'h0, random_num}, {24'h0, 8'd1 << cur_h});
        btn = 8'h00;
        tick(1);
        btn = 8'hFF;
        tick(1);
        chk("multi_score", {24'h0, score}, {24'h0, EXP_AFTER_BOTH});
        chk("multi_mh", {24'h0, mole_hit}, {24'h0, 8'd1 << cur_h});
        btn = 8'h00;
        tick(10);
        chk("r3_round", {24'h0, round_cnt}, 32'd3);

        // Round 4: no presses, game ends
        next_round();
        tick(16);
        chk("g1_over", {31'h0, game_over}, 32'd1);
        chk("g1_round", {24'h0, round_cnt}, 32'd4);
        chk("g1_score", {24'h0, score}, {24'h0, EXP_AFTER_BOTH});
        tick(5);
        chk("g1_hold_go", {31'h0, game_over}, 32'd1);
        chk("g1_hold_grid", {16'h0, random_num, mole_hit}, 32'h0);
        chk("g1_hold_score", {24'h0, score}, {24'h0, EXP_AFTER_BOTH});

        // Game 2: restart from OVER, wrong press at score 0, otherwise idle rounds
        start_game();
        tick(2);
        btn = ~(8'd1 << cur_h);
        tick(1);
        chk("sat0_score", {24'h0, score}, 32'h0);
        btn = 8'h00;
        tick(13);
        for (int r = 0; r < 3; r++) begin
            next_round();
            tick(16);
        end
        chk("g2_over", {31'h0, game_over}, 32'd1);
        chk("g2_round", {24'h0, round_cnt}, 32'd4);
        chk("g2_score", {24'h0, score}, 32'h0);

        // Game 3: three hits, then reset in the middle of round 4
        start_game();
        for (int r = 0; r < 3; r++) begin
            tick(2);
            btn = 8'd1 << cur_h;
            tick(1);
            btn = 8'h00;
            tick(13);
            next_round();
        end
        tick(2);
        chk("g3_score", {24'h0, score}, 32'd3);
        chk("g3_round", {24'h0, round_cnt}, 32'd3);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_outs", {7'h0, random_num, mole_hit, score, round_cnt, game_over}, 32'h0);
        rst_n = 1'b1;
        tick(20);
        chk("midrst_idle", {7'h0, random_num, mole_hit, score, round_cnt, game_over}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
